// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared types and constants for the stepper move sequencer
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam int DEF_CNT_W        = 16;
    localparam int DEF_PER_W        = 16;
    localparam int DEF_POS_W        = 24;
    localparam int MIN_PERIOD_FLOOR = 2;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - loadable step-period down-counter with expire pulse
module step_timer #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [PER_W-1:0] load_val,
    output logic             expire
);

    logic [PER_W-1:0] cnt;

    // Expires on the count of 1 so the registered step pulse lands exactly one period after a load.
    assign expire = en && (cnt == PER_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - PER_W'(1);
        end
    end

endmodule

// File: rtl/stepper_move_ctrl.sv
// rtl/stepper_move_ctrl.sv - move sequencer with linear accel/decel ramp and position tracking
module stepper_move_ctrl
    import stepper_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PER_W       = DEF_PER_W,
    parameter int POS_W       = DEF_POS_W,
    parameter int RAMP_STEP   = 8,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_start_period,
    input  logic [PER_W-1:0] cmd_min_period,
    input  logic             abort,
    output logic             step_pulse,
    output logic             step_dir,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [POS_W-1:0] position,
    output logic [CNT_W-1:0] steps_left
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PER_W-1:0] FLOOR_P = PER_W'(MIN_PERIOD_FLOOR);
    localparam logic [PER_W:0]   RAMP_W  = (PER_W+1)'(RAMP_STEP);

    state_t           state;
    logic [PER_W-1:0] min_p;
    logic [PER_W-1:0] start_p;
    logic [PER_W-1:0] cur_period;
    logic [CNT_W-1:0] ramp_cnt;
    logic [HC_W-1:0]  hold_cnt;
    logic             aborted_lat;

    logic             accept;
    logic             tmr_expire;
    logic             expire_run;
    logic             tmr_load;
    logic [PER_W-1:0] tmr_val;
    logic [PER_W-1:0] cmd_min_c;
    logic [PER_W-1:0] cmd_start_c;
    logic [CNT_W-1:0] steps_dec;
    logic [PER_W:0]   up_sum;
    logic [PER_W:0]   dn_lim;
    logic [PER_W-1:0] next_period;
    logic [CNT_W-1:0] next_ramp;

    assign accept     = cmd_valid && cmd_ready;
    assign expire_run = tmr_expire && (state == ST_RUN) && (steps_left != '0);
    assign cmd_min_c   = (cmd_min_period < FLOOR_P) ? FLOOR_P : cmd_min_period;
    assign cmd_start_c = (cmd_start_period < cmd_min_c) ? cmd_min_c : cmd_start_period;
    assign steps_dec  = steps_left - CNT_W'(1);
    assign up_sum     = {1'b0, cur_period} + RAMP_W;
    assign dn_lim     = {1'b0, min_p} + RAMP_W;
    assign tmr_load   = accept || expire_run;
    assign tmr_val    = accept ? (cmd_start_c - PER_W'(1)) : next_period;

    // Decelerate once the remaining steps fit inside the ramp already climbed, so the ramp mirrors.
    always_comb begin
        next_period = cur_period;
        next_ramp   = ramp_cnt;
        if (steps_dec <= ramp_cnt) begin
            next_period = (up_sum > {1'b0, start_p}) ? start_p : up_sum[PER_W-1:0];
            next_ramp   = (ramp_cnt == '0) ? '0 : ramp_cnt - CNT_W'(1);
        end else if (cur_period > min_p) begin
            next_period = ({1'b0, cur_period} < dn_lim) ? min_p : cur_period - PER_W'(RAMP_STEP);
            next_ramp   = ramp_cnt + CNT_W'(1);
        end
    end

    step_timer #(.PER_W(PER_W)) u_step_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (state == ST_RUN),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cmd_ready   <= 1'b1;
            step_pulse  <= 1'b0;
            step_dir    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            position    <= '0;
            steps_left  <= '0;
            min_p       <= '0;
            start_p     <= '0;
            cur_period  <= '0;
            ramp_cnt    <= '0;
            hold_cnt    <= '0;
            aborted_lat <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        step_dir    <= cmd_dir;
                        min_p       <= cmd_min_c;
                        start_p     <= cmd_start_c;
                        cur_period  <= cmd_start_c;
                        ramp_cnt    <= '0;
                        steps_left  <= cmd_steps;
                        aborted_lat <= 1'b0;
                        cmd_ready   <= 1'b0;
                        if (cmd_steps == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (steps_left == '0) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                    end else if (expire_run) begin
                        step_pulse <= 1'b1;
                        steps_left <= steps_dec;
                        position   <= position + (step_dir ? POS_W'(1) : {POS_W{1'b1}});
                        cur_period <= next_period;
                        ramp_cnt   <= next_ramp;
                        // An abort landing on the final step leaves a normal completion.
                        if (abort && (steps_dec != '0)) begin
                            state       <= ST_HOLD;
                            hold_cnt    <= '0;
                            aborted_lat <= 1'b1;
                        end
                    end else if (abort) begin
                        state       <= ST_HOLD;
                        hold_cnt    <= '0;
                        aborted_lat <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HC_W'(HOLD_CYCLES - 1)) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        aborted <= aborted_lat;
                        busy    <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// tb/tb_stepper_move_ctrl.sv - directed self-checking bench for stepper_move_ctrl
module tb_stepper_move_ctrl;

    localparam int HOLD = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_start_period;
    logic [15:0] cmd_min_period;
    logic        abort;
    logic        step_pulse;
    logic        step_dir;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [23:0] position;
    logic [15:0] steps_left;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulse_q[$];
    int          done_cyc;
    logic        done_abt;
    logic        done_seen;
    logic [15:0] sl_at_done;
    logic [23:0] pos_at_done;
    int          exp_pos = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stepper_move_ctrl #(
        .CNT_W(16), .PER_W(16), .POS_W(24), .RAMP_STEP(8), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_dir          (cmd_dir),
        .cmd_steps        (cmd_steps),
        .cmd_start_period (cmd_start_period),
        .cmd_min_period   (cmd_min_period),
        .abort            (abort),
        .step_pulse       (step_pulse),
        .step_dir         (step_dir),
        .busy             (busy),
        .done             (done),
        .aborted          (aborted),
        .position         (position),
        .steps_left       (steps_left)
    );

    task automatic send_cmd(input logic d, input int steps, input int sp, input int mp, output int t);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir = d;
        cmd_steps = 16'(steps);
        cmd_start_period = 16'(sp);
        cmd_min_period = 16'(mp);
        t = cyc;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_ready_at_accept: got %b expected 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_done(input int abort_cyc, input int budget);
        pulse_q.delete();
        done_seen = 1'b0;
        done_cyc = 0;
        done_abt = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            abort = (cyc == abort_cyc);
            if (step_pulse === 1'b1) pulse_q.push_back(cyc);
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_cyc = cyc;
                done_abt = aborted;
                sl_at_done = steps_left;
                pos_at_done = position;
                break;
            end
        end
        abort = 1'b0;
        n_checks++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", budget);
        end
    endtask

    task automatic test_reset();
        int np;
        np = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (step_pulse !== 1'b0) np++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        n_checks++;
        if (position !== 24'd0) begin n_fail++; $display("FAIL reset_position: got %0d expected 0", position); end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got busy=%b done=%b aborted=%b expected 0", busy, done, aborted);
        end
        n_checks++;
        if (np != 0) begin n_fail++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", np); end
    endtask

    task automatic test_basic();
        int t;
        send_cmd(1'b1, 4, 10, 10, t);
        n_checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy: got busy=%b ready=%b expected 1/0", busy, cmd_ready);
        end
        run_until_done(-1, 2000);
        exp_pos += 4;
        n_checks++;
        if (pulse_q.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", pulse_q.size()); end
        for (int i = 0; i < pulse_q.size() && i < 4; i++) begin
            n_checks++;
            if (pulse_q[i] != t + 10 * (i + 1)) begin
                n_fail++; $display("FAIL basic_pulse%0d: got T+%0d expected T+%0d", i, pulse_q[i] - t, 10 * (i + 1));
            end
        end
        n_checks++;
        if (done_cyc != t + 40 + HOLD + 1) begin
            n_fail++; $display("FAIL basic_done_time: got T+%0d expected T+%0d", done_cyc - t, 40 + HOLD + 1);
        end
        n_checks++;
        if (done_abt !== 1'b0) begin n_fail++; $display("FAIL basic_aborted: got %b expected 0", done_abt); end
        n_checks++;
        if (pos_at_done !== 24'(exp_pos)) begin n_fail++; $display("FAIL basic_position: got %0d expected %0d", pos_at_done, exp_pos); end
        n_checks++;
        if (step_dir !== 1'b1) begin n_fail++; $display("FAIL basic_dir: got %b expected 1", step_dir); end
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_ramp();
        int t;
        int prev;
        int sp[10];
        sp = '{40, 32, 24, 24, 24, 24, 24, 24, 32, 40};
        send_cmd(1'b0, 10, 40, 24, t);
        run_until_done(-1, 3000);
        exp_pos -= 10;
        n_checks++;
        if (pulse_q.size() != 10) begin n_fail++; $display("FAIL ramp_count: got %0d expected 10", pulse_q.size()); end
        prev = t;
        for (int i = 0; i < pulse_q.size() && i < 10; i++) begin
            n_checks++;
            if (pulse_q[i] - prev != sp[i]) begin
                n_fail++; $display("FAIL ramp_spacing%0d: got %0d expected %0d", i, pulse_q[i] - prev, sp[i]);
            end
            prev = pulse_q[i];
        end
        n_checks++;
        if (done_cyc != prev + HOLD + 1) begin n_fail++; $display("FAIL ramp_done_time: got %0d expected %0d", done_cyc, prev + HOLD + 1); end
        n_checks++;
        if (pos_at_done !== 24'(exp_pos)) begin n_fail++; $display("FAIL ramp_position: got %0d expected %0d", pos_at_done, 24'(exp_pos)); end
        n_checks++;
        if (step_dir !== 1'b0) begin n_fail++; $display("FAIL ramp_dir: got %b expected 0", step_dir); end
    endtask

    task automatic test_zero_and_clamp();
        int t;
        send_cmd(1'b1, 0, 50, 20, t);
        run_until_done(-1, 50);
        n_checks++;
        if (done_cyc != t + 1) begin n_fail++; $display("FAIL zero_done_time: got T+%0d expected T+1", done_cyc - t); end
        n_checks++;
        if (pulse_q.size() != 0 || done_abt !== 1'b0) begin
            n_fail++; $display("FAIL zero_no_pulse: got %0d pulses aborted=%b expected 0/0", pulse_q.size(), done_abt);
        end
        send_cmd(1'b1, 3, 1, 0, t);
        run_until_done(-1, 2000);
        exp_pos += 3;
        n_checks++;
        if (pulse_q.size() != 3) begin n_fail++; $display("FAIL clamp_count: got %0d expected 3", pulse_q.size()); end
        for (int i = 0; i < pulse_q.size() && i < 3; i++) begin
            n_checks++;
            if (pulse_q[i] != t + 2 * (i + 1)) begin
                n_fail++; $display("FAIL clamp_pulse%0d: got T+%0d expected T+%0d", i, pulse_q[i] - t, 2 * (i + 1));
            end
        end
    endtask

    task automatic test_abort();
        int t;
        send_cmd(1'b1, 20, 10, 10, t);
        run_until_done(t + 30, 3000);
        exp_pos += 3;
        n_checks++;
        if (pulse_q.size() != 3) begin n_fail++; $display("FAIL abort_count: got %0d expected 3", pulse_q.size()); end
        n_checks++;
        if (sl_at_done !== 16'd17) begin n_fail++; $display("FAIL abort_steps_left: got %0d expected 17", sl_at_done); end
        n_checks++;
        if (done_cyc != t + 30 + HOLD + 1) begin n_fail++; $display("FAIL abort_done_time: got T+%0d expected T+%0d", done_cyc - t, 30 + HOLD + 1); end
        n_checks++;
        if (done_abt !== 1'b1) begin n_fail++; $display("FAIL abort_flag: got %b expected 1", done_abt); end
        n_checks++;
        if (pos_at_done !== 24'(exp_pos)) begin n_fail++; $display("FAIL abort_position: got %0d expected %0d", pos_at_done, exp_pos); end
    endtask

    task automatic test_abort_last();
        int t;
        send_cmd(1'b0, 2, 10, 10, t);
        run_until_done(t + 19, 3000);
        exp_pos -= 2;
        n_checks++;
        if (pulse_q.size() != 2) begin n_fail++; $display("FAIL abort_last_count: got %0d expected 2", pulse_q.size()); end
        n_checks++;
        if (done_cyc != t + 20 + HOLD + 1) begin n_fail++; $display("FAIL abort_last_done_time: got T+%0d expected T+%0d", done_cyc - t, 20 + HOLD + 1); end
        n_checks++;
        if (done_abt !== 1'b0) begin n_fail++; $display("FAIL abort_last_flag: got %b expected 0", done_abt); end
        n_checks++;
        if (pos_at_done !== 24'(exp_pos)) begin n_fail++; $display("FAIL abort_last_position: got %0d expected %0d", pos_at_done, 24'(exp_pos)); end
    endtask

    task automatic test_reset_mid_run();
        int t;
        send_cmd(1'b1, 50, 10, 10, t);
        repeat (35) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || steps_left !== 16'd47) begin
            n_fail++; $display("FAIL midrun_state: got busy=%b steps_left=%0d expected 1/47", busy, steps_left);
        end
        reset_n = 1'b0;
        #1;
        exp_pos = 0;
        n_checks++;
        if (step_pulse !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || step_dir !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset_flags: got pulse=%b busy=%b done=%b aborted=%b dir=%b expected 0",
                               step_pulse, busy, done, aborted, step_dir);
        end
        n_checks++;
        if (position !== 24'd0 || steps_left !== 16'd0) begin
            n_fail++; $display("FAIL midrun_reset_counts: got pos=%0d steps_left=%0d expected 0/0", position, steps_left);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || position !== 24'd0) begin
            n_fail++; $display("FAIL midrun_after_release: got ready=%b busy=%b pos=%0d expected 1/0/0", cmd_ready, busy, position);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir = 1'b0;
        cmd_steps = '0;
        cmd_start_period = '0;
        cmd_min_period = '0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_basic();
        test_ramp();
        test_zero_and_clamp();
        test_abort();
        test_abort_last();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
